i2c_master_byte_engine: RTL and testbench

I2C_MASTER_BYTE_ENGINE -- requirements
Module: i2c_master_byte_engine

---
 rtl/i2c_pkg.sv | 18 +
 rtl/i2c_quarter_tick_gen.sv | 36 +++
 rtl/i2c_master_byte_engine.sv | 207 ++++++++++++++++++++
 tb/tb_i2c_master_byte_engine.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master byte engine: state encoding and sizing constants.
package i2c_pkg;

   localparam int CLK_DIV_DEFAULT = 125;
   localparam int MAX_BYTES       = 32;

   typedef enum logic [2:0] {
      IDLE,
      START,
      ADDR,
      ADDR_ACK,
      WDATA,
      RDATA,
      DATA_ACK,
      STOP
   } state_t;

endpackage

// File: rtl/i2c_quarter_tick_gen.sv
// Divides the system clock into SCL quarter periods and tracks which quarter of the bit is active.
module i2c_quarter_tick_gen
   import i2c_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       hold,
   output logic       tick,
   output logic [1:0] quarter
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] div_cnt;

   assign tick = !hold && (div_cnt == CW'(CLK_DIV - 1));

   // Free-running quarter divider, parked at quarter 0 whenever the engine is idle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt <= '0;
         quarter <= '0;
      end else if (hold) begin
         div_cnt <= '0;
         quarter <= '0;
      end else if (tick) begin
         div_cnt <= '0;
         quarter <= quarter + 2'd1;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/i2c_master_byte_engine.sv
// I2C master that runs one addressed transaction of up to 32 data bytes, with a per-byte handshake.
module i2c_master_byte_engine
   import i2c_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       go,
   input  logic       rw,
   input  logic [5:0] N_Byte,
   input  logic [6:0] dev_add,
   input  logic [7:0] dwr_DataWriteReg,
   input  logic       stop,
   output logic       done,
   output logic       ready,
   output logic       ack_e,
   output logic [7:0] drd_lcdData,
   output logic       scl,
   output logic       sda_oe,
   input  logic       sda_in
);

   state_t     state, state_next;
   logic       tick;
   logic [1:0] quarter;
   logic       sample_edge, bit_end, scl_mid;

   logic [2:0] bit_cnt, bit_cnt_next;
   logic [5:0] byte_cnt, byte_cnt_next;
   logic [7:0] shift_reg, shift_next;
   logic [7:0] rd_data_next;
   logic [6:0] addr_lat, addr_next;
   logic       rw_lat, rw_next;
   logic       done_next, ack_e_next;
   logic       stop_pend, stop_pend_next;
   logic       proceed, proceed_next;
   logic       master_ack, master_ack_next;

   i2c_quarter_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk    (clk),
      .reset  (reset),
      .hold   (state == IDLE),
      .tick   (tick),
      .quarter(quarter)
   );

   assign sample_edge = tick && (quarter == 2'd2);
   assign bit_end     = tick && (quarter == 2'd3);
   assign scl_mid     = (quarter == 2'd1) || (quarter == 2'd2);

   // State and datapath registers; reset parks the bus released with SCL high and no STOP emitted
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         byte_cnt    <= '0;
         shift_reg   <= '0;
         drd_lcdData <= '0;
         addr_lat    <= '0;
         rw_lat      <= 1'b0;
         done        <= 1'b1;
         ack_e       <= 1'b0;
         stop_pend   <= 1'b0;
         proceed     <= 1'b0;
         master_ack  <= 1'b0;
      end else begin
         state       <= state_next;
         bit_cnt     <= bit_cnt_next;
         byte_cnt    <= byte_cnt_next;
         shift_reg   <= shift_next;
         drd_lcdData <= rd_data_next;
         addr_lat    <= addr_next;
         rw_lat      <= rw_next;
         done        <= done_next;
         ack_e       <= ack_e_next;
         stop_pend   <= stop_pend_next;
         proceed     <= proceed_next;
         master_ack  <= master_ack_next;
      end
   end

   // Next-state and bus-level decode; continue/abort is decided at the ACK sample so ready is stable for all of q3
   always_comb begin
      state_next      = state;
      bit_cnt_next    = bit_cnt;
      byte_cnt_next   = byte_cnt;
      shift_next      = shift_reg;
      rd_data_next    = drd_lcdData;
      addr_next       = addr_lat;
      rw_next         = rw_lat;
      done_next       = done;
      ack_e_next      = ack_e;
      stop_pend_next  = stop_pend | stop;
      proceed_next    = proceed;
      master_ack_next = master_ack;
      scl             = 1'b1;
      sda_oe          = 1'b0;
      ready           = 1'b0;

      unique case (state)
         IDLE: begin
            done_next = 1'b1;
            if (done && go) begin
               state_next     = START;
               done_next      = 1'b0;
               ack_e_next     = 1'b0;
               stop_pend_next = 1'b0;
               rw_next        = rw;
               addr_next      = dev_add;
               byte_cnt_next  = (N_Byte > 6'(MAX_BYTES)) ? 6'(MAX_BYTES) : N_Byte;
            end
         end
         START: begin
            scl    = (quarter != 2'd3);
            sda_oe = (quarter != 2'd0);
            if (bit_end) begin
               state_next   = ADDR;
               shift_next   = {addr_lat, rw_lat};
               bit_cnt_next = 3'd7;
            end
         end
         ADDR, WDATA: begin
            scl    = scl_mid;
            sda_oe = !shift_reg[7];
            if (bit_end) begin
               if (bit_cnt == 3'd0) begin
                  state_next = (state == ADDR) ? ADDR_ACK : DATA_ACK;
               end else begin
                  shift_next   = {shift_reg[6:0], 1'b0};
                  bit_cnt_next = bit_cnt - 3'd1;
               end
            end
         end
         ADDR_ACK: begin
            scl   = scl_mid;
            ready = !rw_lat && proceed && (quarter == 2'd3);
            if (sample_edge) begin
               if (sda_in) ack_e_next = 1'b1;
               proceed_next = !sda_in && (byte_cnt != 6'd0) && !stop_pend && !stop;
            end
            if (bit_end) begin
               bit_cnt_next = 3'd7;
               if (!proceed) begin
                  state_next = STOP;
               end else if (rw_lat) begin
                  state_next = RDATA;
               end else begin
                  state_next = WDATA;
                  shift_next = dwr_DataWriteReg;
               end
            end
         end
         RDATA: begin
            scl   = scl_mid;
            ready = (bit_cnt == 3'd0) && (quarter == 2'd3);
            if (sample_edge) begin
               shift_next = {shift_reg[6:0], sda_in};
               if (bit_cnt == 3'd0) rd_data_next = {shift_reg[6:0], sda_in};
            end
            if (bit_end) begin
               if (bit_cnt == 3'd0) begin
                  state_next      = DATA_ACK;
                  master_ack_next = (byte_cnt > 6'd1) && !stop_pend && !stop;
               end else begin
                  bit_cnt_next = bit_cnt - 3'd1;
               end
            end
         end
         DATA_ACK: begin
            scl    = scl_mid;
            sda_oe = rw_lat && master_ack;
            ready  = !rw_lat && proceed && (quarter == 2'd3);
            if (sample_edge) begin
               if (byte_cnt != 6'd0) byte_cnt_next = byte_cnt - 6'd1;
               if (rw_lat) begin
                  proceed_next = master_ack;
               end else begin
                  if (sda_in) ack_e_next = 1'b1;
                  proceed_next = !sda_in && (byte_cnt > 6'd1) && !stop_pend && !stop;
               end
            end
            if (bit_end) begin
               bit_cnt_next = 3'd7;
               if (!proceed) begin
                  state_next = STOP;
               end else if (rw_lat) begin
                  state_next = RDATA;
               end else begin
                  state_next = WDATA;
                  shift_next = dwr_DataWriteReg;
               end
            end
         end
         STOP: begin
            scl    = (quarter != 2'd0);
            sda_oe = (quarter != 2'd3);
            if (bit_end) begin
               state_next     = IDLE;
               stop_pend_next = 1'b0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_i2c_master_byte_engine.sv
// Directed bench for the I2C master byte engine with a bus-level slave model on SCL/SDA.
module tb_i2c_master_byte_engine;

   localparam int CLK_DIV = 4;
   localparam int LIMIT   = 4000;

   logic       clk = 1'b0;
   logic       reset, go, rw, stop;
   logic [5:0] N_Byte;
   logic [6:0] dev_add;
   logic [7:0] dwr_DataWriteReg;
   logic       done, ready, ack_e, scl, sda_oe, sda_in;
   logic [7:0] drd_lcdData;

   logic       slave_low = 1'b0;
   logic       sda_line;
   assign sda_line = ~(sda_oe | slave_low);
   assign sda_in   = sda_line;

   int total = 0;
   int bad   = 0;

   // Slave configuration (written by tests) and observation logs (written by the slave)
   logic       addr_ack_en = 1'b1;
   logic [7:0] tx_bytes [0:7];
   logic [7:0] rx_bytes [0:63];
   logic       mack_log [0:63];
   logic [7:0] last_addr = 8'h00;
   int start_total = 0, stop_total = 0, rx_total = 0, mack_total = 0;

   // Transaction driver results
   logic [7:0] wr_data [0:31];
   logic [7:0] rd_cap  [0:31];
   int ready_cnt, width_bad, start_base, stop_base, rx_base, mack_base;
   logic timed_out, done_after_go, ack_e_after_go;

   i2c_master_byte_engine #(.CLK_DIV(CLK_DIV)) dut (
      .clk             (clk),
      .reset           (reset),
      .go              (go),
      .rw              (rw),
      .N_Byte          (N_Byte),
      .dev_add         (dev_add),
      .dwr_DataWriteReg(dwr_DataWriteReg),
      .stop            (stop),
      .done            (done),
      .ready           (ready),
      .ack_e           (ack_e),
      .drd_lcdData     (drd_lcdData),
      .scl             (scl),
      .sda_oe          (sda_oe),
      .sda_in          (sda_in)
   );

   always #5 clk = ~clk;

   // Bus-level slave: detects START/STOP, shifts bits on SCL rise, drives ACK/read data on SCL fall
   logic scl_prev = 1'b1, sda_prev = 1'b1;
   logic in_xfer = 1'b0, reading = 1'b0, tx_on = 1'b0;
   logic [7:0] sh = 8'h00;
   int bit_idx = 0, byte_idx = 0;
   always @(scl or sda_line or reset) begin
      if (!reset) begin
         in_xfer = 1'b0; tx_on = 1'b0; slave_low = 1'b0;
      end else if (scl && scl_prev && sda_prev && !sda_line) begin
         start_total++; in_xfer = 1'b1; bit_idx = 0; byte_idx = 0;
         reading = 1'b0; tx_on = 1'b0; slave_low = 1'b0;
      end else if (scl && scl_prev && !sda_prev && sda_line) begin
         stop_total++; in_xfer = 1'b0; tx_on = 1'b0; slave_low = 1'b0;
      end else if (in_xfer && scl && !scl_prev) begin
         if (bit_idx < 8) sh = {sh[6:0], sda_line};
         else if (reading && byte_idx > 0) begin
            mack_log[6'(mack_total)] = sda_line; mack_total++;
         end
         bit_idx++;
      end else if (in_xfer && !scl && scl_prev && bit_idx > 0) begin
         if (bit_idx == 8) begin
            if (byte_idx == 0) begin
               last_addr = sh; reading = sh[0]; slave_low = addr_ack_en;
            end else if (!reading) begin
               rx_bytes[6'(rx_total)] = sh; rx_total++; slave_low = 1'b1;
            end else slave_low = 1'b0;
         end else if (bit_idx == 9) begin
            if (byte_idx == 0) tx_on = reading && addr_ack_en;
            else               tx_on = reading && !mack_log[6'(mack_total - 1)];
            byte_idx++; bit_idx = 0;
            slave_low = tx_on && !tx_bytes[3'(byte_idx - 1)][7];
         end else if (tx_on) begin
            slave_low = !tx_bytes[3'(byte_idx - 1)][3'(7 - bit_idx)];
         end
      end
      scl_prev = scl; sda_prev = sda_line;
   end

   // Issues one transaction and follows it to done, feeding write bytes and logging ready pulses
   task automatic run_txn(input logic r, input logic [5:0] n, input logic [6:0] a,
                          input int stop_byte, input int go_again_cyc);
      int cyc, width, post;
      logic rprev;
      start_base = start_total; stop_base = stop_total;
      rx_base = rx_total; mack_base = mack_total;
      @(negedge clk);
      rw = r; N_Byte = n; dev_add = a; go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      done_after_go = done; ack_e_after_go = ack_e;
      ready_cnt = 0; width_bad = 0; width = 0; post = 0; cyc = 0; rprev = 1'b0;
      while (done !== 1'b1 && cyc < LIMIT) begin
         stop = 1'b0; go = 1'b0;
         if (ready) begin
            if (!rprev) begin
               if (ready_cnt < 32) begin
                  rd_cap[5'(ready_cnt)] = drd_lcdData;
                  dwr_DataWriteReg = wr_data[5'(ready_cnt)];
               end
               ready_cnt++; width = 0;
            end
            width++;
         end else if (rprev && width != CLK_DIV) width_bad++;
         rprev = ready;
         if (stop_byte > 0 && ready_cnt == stop_byte && !ready) begin
            post++;
            if (post == 20) stop = 1'b1;
         end
         if (cyc == go_again_cyc) begin go = 1'b1; dev_add = 7'h12; end
         @(negedge clk);
         cyc++;
      end
      stop = 1'b0; go = 1'b0;
      timed_out = (done !== 1'b1);
   endtask

   task automatic test_reset;
      reset = 1'b0; go = 1'b0; rw = 1'b0; stop = 1'b0;
      N_Byte = '0; dev_add = '0; dwr_DataWriteReg = '0;
      for (int i = 0; i < 32; i++) wr_data[i] = 8'(i);
      repeat (3) @(negedge clk);
      total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL rst_done got=%b exp=1", done); end
      total++; if (scl !== 1'b1) begin bad++; $display("[TB] FAIL rst_scl got=%b exp=1", scl); end
      total++; if (sda_oe !== 1'b0) begin bad++; $display("[TB] FAIL rst_sda_oe got=%b exp=0", sda_oe); end
      total++; if (ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_ready got=%b exp=0", ready); end
      total++; if (ack_e !== 1'b0) begin bad++; $display("[TB] FAIL rst_ack_e got=%b exp=0", ack_e); end
      total++; if (drd_lcdData !== 8'h00) begin bad++; $display("[TB] FAIL rst_drd got=%h exp=00", drd_lcdData); end
      reset = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (done !== 1'b1 || scl !== 1'b1) begin bad++; $display("[TB] FAIL rst_idle done=%b scl=%b exp=1,1", done, scl); end
   endtask

   task automatic test_write;
      addr_ack_en = 1'b1; wr_data[0] = 8'hA5; wr_data[1] = 8'h3C;
      run_txn(1'b0, 6'd2, 7'h67, 0, 60);
      total++; if (timed_out) begin bad++; $display("[TB] FAIL wr_timeout got=1 exp=0"); end
      total++; if (done_after_go !== 1'b0) begin bad++; $display("[TB] FAIL wr_done_fall got=%b exp=0", done_after_go); end
      total++; if (last_addr !== 8'hCE) begin bad++; $display("[TB] FAIL wr_addr got=%h exp=CE", last_addr); end
      total++; if (rx_total - rx_base != 2) begin bad++; $display("[TB] FAIL wr_nbytes got=%0d exp=2", rx_total - rx_base); end
      total++; if (rx_bytes[6'(rx_base)] !== 8'hA5) begin bad++; $display("[TB] FAIL wr_byte0 got=%h exp=A5", rx_bytes[6'(rx_base)]); end
      total++; if (rx_bytes[6'(rx_base + 1)] !== 8'h3C) begin bad++; $display("[TB] FAIL wr_byte1 got=%h exp=3C", rx_bytes[6'(rx_base + 1)]); end
      total++; if (ready_cnt != 2) begin bad++; $display("[TB] FAIL wr_ready_cnt got=%0d exp=2", ready_cnt); end
      total++; if (width_bad != 0) begin bad++; $display("[TB] FAIL wr_ready_width bad_pulses=%0d exp=0", width_bad); end
      total++; if (ack_e !== 1'b0) begin bad++; $display("[TB] FAIL wr_ack_e got=%b exp=0", ack_e); end
      total++; if (stop_total - stop_base != 1) begin bad++; $display("[TB] FAIL wr_stop got=%0d exp=1", stop_total - stop_base); end
      total++; if (scl !== 1'b1 || sda_oe !== 1'b0) begin bad++; $display("[TB] FAIL wr_bus_idle scl=%b sda_oe=%b exp=1,0", scl, sda_oe); end
      repeat (40) @(negedge clk);
      total++; if (start_total - start_base != 1 || done !== 1'b1) begin bad++; $display("[TB] FAIL wr_busy_go starts=%0d done=%b exp=1,1", start_total - start_base, done); end
   endtask

   task automatic test_read;
      tx_bytes[0] = 8'h11; tx_bytes[1] = 8'h22; tx_bytes[2] = 8'h33; addr_ack_en = 1'b1;
      run_txn(1'b1, 6'd3, 7'h2A, 0, -1);
      total++; if (timed_out) begin bad++; $display("[TB] FAIL rd_timeout got=1 exp=0"); end
      total++; if (last_addr !== 8'h55) begin bad++; $display("[TB] FAIL rd_addr got=%h exp=55", last_addr); end
      total++; if (ready_cnt != 3) begin bad++; $display("[TB] FAIL rd_ready_cnt got=%0d exp=3", ready_cnt); end
      total++; if (rd_cap[0] !== 8'h11) begin bad++; $display("[TB] FAIL rd_byte0 got=%h exp=11", rd_cap[0]); end
      total++; if (rd_cap[1] !== 8'h22) begin bad++; $display("[TB] FAIL rd_byte1 got=%h exp=22", rd_cap[1]); end
      total++; if (rd_cap[2] !== 8'h33) begin bad++; $display("[TB] FAIL rd_byte2 got=%h exp=33", rd_cap[2]); end
      total++; if (mack_total - mack_base != 3) begin bad++; $display("[TB] FAIL rd_ack_slots got=%0d exp=3", mack_total - mack_base); end
      total++; if ({mack_log[6'(mack_base)], mack_log[6'(mack_base + 1)], mack_log[6'(mack_base + 2)]} !== 3'b001)
         begin bad++; $display("[TB] FAIL rd_master_acks got=%b%b%b exp=001", mack_log[6'(mack_base)], mack_log[6'(mack_base + 1)], mack_log[6'(mack_base + 2)]); end
      total++; if (width_bad != 0) begin bad++; $display("[TB] FAIL rd_ready_width bad_pulses=%0d exp=0", width_bad); end
      total++; if (stop_total - stop_base != 1 || ack_e !== 1'b0) begin bad++; $display("[TB] FAIL rd_end stops=%0d ack_e=%b exp=1,0", stop_total - stop_base, ack_e); end
   endtask

   task automatic test_addr_nack;
      addr_ack_en = 1'b0;
      run_txn(1'b0, 6'd2, 7'h50, 0, -1);
      total++; if (timed_out) begin bad++; $display("[TB] FAIL nack_timeout got=1 exp=0"); end
      total++; if (ready_cnt != 0) begin bad++; $display("[TB] FAIL nack_ready_cnt got=%0d exp=0", ready_cnt); end
      total++; if (ack_e !== 1'b1) begin bad++; $display("[TB] FAIL nack_ack_e got=%b exp=1", ack_e); end
      total++; if (stop_total - stop_base != 1 || rx_total != rx_base) begin bad++; $display("[TB] FAIL nack_bus stops=%0d rx=%0d exp=1,0", stop_total - stop_base, rx_total - rx_base); end
      addr_ack_en = 1'b1; wr_data[0] = 8'h5A;
      run_txn(1'b0, 6'd1, 7'h50, 0, -1);
      total++; if (ack_e_after_go !== 1'b0) begin bad++; $display("[TB] FAIL nack_clear_on_go got=%b exp=0", ack_e_after_go); end
      total++; if (ack_e !== 1'b0 || ready_cnt != 1) begin bad++; $display("[TB] FAIL nack_retry ack_e=%b ready=%0d exp=0,1", ack_e, ready_cnt); end
      total++; if (rx_bytes[6'(rx_base)] !== 8'h5A) begin bad++; $display("[TB] FAIL nack_retry_byte got=%h exp=5A", rx_bytes[6'(rx_base)]); end
   endtask

   task automatic test_abort;
      addr_ack_en = 1'b1; wr_data[0] = 8'hF0; wr_data[1] = 8'h0F;
      run_txn(1'b0, 6'd32, 7'h67, 2, -1);
      total++; if (timed_out) begin bad++; $display("[TB] FAIL abort_timeout got=1 exp=0"); end
      total++; if (ready_cnt != 2) begin bad++; $display("[TB] FAIL abort_ready_cnt got=%0d exp=2", ready_cnt); end
      total++; if (rx_total - rx_base != 2) begin bad++; $display("[TB] FAIL abort_nbytes got=%0d exp=2", rx_total - rx_base); end
      total++; if (rx_bytes[6'(rx_base + 1)] !== 8'h0F) begin bad++; $display("[TB] FAIL abort_byte1 got=%h exp=0F", rx_bytes[6'(rx_base + 1)]); end
      total++; if (stop_total - stop_base != 1 || ack_e !== 1'b0) begin bad++; $display("[TB] FAIL abort_end stops=%0d ack_e=%b exp=1,0", stop_total - stop_base, ack_e); end
   endtask

   task automatic test_probe;
      addr_ack_en = 1'b1;
      run_txn(1'b0, 6'd0, 7'h67, 0, -1);
      total++; if (timed_out) begin bad++; $display("[TB] FAIL probe_timeout got=1 exp=0"); end
      total++; if (ready_cnt != 0) begin bad++; $display("[TB] FAIL probe_ready_cnt got=%0d exp=0", ready_cnt); end
      total++; if (last_addr !== 8'hCE) begin bad++; $display("[TB] FAIL probe_addr got=%h exp=CE", last_addr); end
      total++; if (rx_total != rx_base || ack_e !== 1'b0) begin bad++; $display("[TB] FAIL probe_data rx=%0d ack_e=%b exp=0,0", rx_total - rx_base, ack_e); end
      total++; if (start_total - start_base != 1 || stop_total - stop_base != 1) begin bad++; $display("[TB] FAIL probe_conds start=%0d stop=%0d exp=1,1", start_total - start_base, stop_total - stop_base); end
   endtask

   task automatic test_reset_mid_read;
      tx_bytes[0] = 8'h96; tx_bytes[1] = 8'h69; addr_ack_en = 1'b1;
      @(negedge clk);
      rw = 1'b1; N_Byte = 6'd2; dev_add = 7'h2A; go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      repeat (200) @(negedge clk);
      total++; if (done !== 1'b0 || sda_oe !== 1'b0) begin bad++; $display("[TB] FAIL mid_busy done=%b sda_oe=%b exp=0,0", done, sda_oe); end
      #2 reset = 1'b0;
      #1;
      total++; if (scl !== 1'b1) begin bad++; $display("[TB] FAIL mid_rst_scl got=%b exp=1", scl); end
      total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL mid_rst_done got=%b exp=1", done); end
      total++; if (sda_oe !== 1'b0 || ready !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_oe_ready got=%b%b exp=00", sda_oe, ready); end
      total++; if (drd_lcdData !== 8'h00) begin bad++; $display("[TB] FAIL mid_rst_drd got=%h exp=00", drd_lcdData); end
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      wr_data[0] = 8'hC3;
      run_txn(1'b0, 6'd1, 7'h33, 0, -1);
      total++; if (timed_out) begin bad++; $display("[TB] FAIL mid_restart_timeout got=1 exp=0"); end
      total++; if (last_addr !== 8'h66) begin bad++; $display("[TB] FAIL mid_restart_addr got=%h exp=66", last_addr); end
      total++; if (rx_bytes[6'(rx_base)] !== 8'hC3 || ready_cnt != 1) begin bad++; $display("[TB] FAIL mid_restart_data got=%h ready=%0d exp=C3,1", rx_bytes[6'(rx_base)], ready_cnt); end
      total++; if (ack_e !== 1'b0 || stop_total - stop_base != 1) begin bad++; $display("[TB] FAIL mid_restart_end ack_e=%b stops=%0d exp=0,1", ack_e, stop_total - stop_base); end
   endtask

   initial begin
      test_reset;
      test_write;
      test_read;
      test_addr_nack;
      test_abort;
      test_probe;
      test_reset_mid_read;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
